// File: rtl/pipe_lane_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_lane_array                                                  |
// | Brief    : LANES x WIDTH vector pipeline with stall/flush, lane masks,      |
// |            occupancy and saturating drop counter.                           |
// |            Define PIPE_BUBBLE_COLLAPSE_EN for per-stage elastic advance.    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipe_lane_array #(
    parameter int LANES = 8,
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int DROPW = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [LANES*WIDTH-1:0]      in_data,
    input  logic [LANES-1:0]            in_mask,
    output logic                        in_ready,
    input  logic                        stall,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [LANES*WIDTH-1:0]      out_data,
    output logic [LANES-1:0]            out_mask,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic [DROPW-1:0]            drop_count
);

    localparam int c_OCCW = $clog2(DEPTH+1);
    localparam int c_DW   = LANES*WIDTH;

    logic [DEPTH-1:0]   r_valid;
    logic [c_DW-1:0]    r_data [DEPTH];
    logic [LANES-1:0]   r_mask [DEPTH];
    logic [c_OCCW-1:0]  r_occ;
    logic [DROPW-1:0]   r_drop;

    logic [c_DW-1:0]    w_cap_data;
    logic               w_src_valid [DEPTH];
    logic [c_DW-1:0]    w_src_data  [DEPTH];
    logic [LANES-1:0]   w_src_mask  [DEPTH];
    logic [DEPTH-1:0]   w_ready;
    logic [DEPTH-1:0]   w_valid_nxt;
    logic [c_OCCW-1:0]  w_occ_nxt;

    // Masked-off lanes enter as zero so they stay zero all the way down.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_cap_data[i*WIDTH +: WIDTH] = in_mask[i] ? in_data[i*WIDTH +: WIDTH] : '0;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_src
        if (k == 0) begin : g_head
            assign w_src_valid[k] = in_valid;
            assign w_src_data[k]  = w_cap_data;
            assign w_src_mask[k]  = in_mask;
        end else begin : g_body
            assign w_src_valid[k] = r_valid[k-1];
            assign w_src_data[k]  = r_data[k-1];
            assign w_src_mask[k]  = r_mask[k-1];
        end
    end

    always_comb begin : p_ready
        logic l_rdy;
        w_ready = '0;
        l_rdy   = !stall;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
        // A stage may accept when it is empty or its occupant moves on.
        for (int k = DEPTH-1; k >= 0; k--) begin
            w_ready[k] = !r_valid[k] || l_rdy;
            l_rdy      = w_ready[k];
        end
`else
        w_ready = {DEPTH{l_rdy}};
`endif
    end

    always_comb begin
        w_valid_nxt = '0;
        w_occ_nxt   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush)
                w_valid_nxt[k] = 1'b0;
            else if (w_ready[k])
                w_valid_nxt[k] = w_src_valid[k];
            else
                w_valid_nxt[k] = r_valid[k];
            w_occ_nxt = w_occ_nxt + c_OCCW'(w_valid_nxt[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
                r_mask[k] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_ready[k] && !flush) begin
                    r_data[k] <= w_src_data[k];
                    r_mask[k] <= w_src_mask[k];
                end
            end
        end
    end

    // Flush is a deliberate discard, so it never counts as a drop.
    always_ff @(posedge clk) begin
        if (reset)
            r_drop <= '0;
        else if (in_valid && !in_ready && !flush && (r_drop != {DROPW{1'b1}}))
            r_drop <= r_drop + 1'b1;
    end

    assign in_ready   = w_ready[0] && !flush;
    assign out_valid  = r_valid[DEPTH-1];
    assign out_data   = r_data[DEPTH-1];
    assign out_mask   = r_mask[DEPTH-1];
    assign occupancy  = r_occ;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pipe_lane_array.sv
`default_nettype none
// Randomized bench for pipe_lane_array against a slot-list reference model.
module tb_pipe_lane_array;

    localparam int LANES = 8;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int DROPW = 4;
    localparam int DW    = LANES*WIDTH;
    localparam int DMAX  = (1 << DROPW) - 1;

    logic                       clk = 1'b0;
    logic                       reset, in_valid, in_ready, stall, flush, out_valid;
    logic [DW-1:0]              in_data, out_data;
    logic [LANES-1:0]           in_mask, out_mask;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [DROPW-1:0]           drop_count;

    always #5 clk = ~clk;

    pipe_lane_array #(
        .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .DROPW(DROPW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_mask(in_mask), .in_ready(in_ready),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_mask(out_mask),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    typedef struct {
        bit               v;
        logic [DW-1:0]    d;
        logic [LANES-1:0] m;
    } slot_t;

    slot_t mdl [DEPTH];
    int    mdrop = 0;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] masked(input logic [DW-1:0] d, input logic [LANES-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            if (m[i]) r[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
        return r;
    endfunction

    // Can the pipe take a vector this cycle?
    function automatic bit mdl_ready(input bit st, input bit fl);
        bit free;
        if (fl) return 1'b0;
        free = !st;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
        for (int k = DEPTH-1; k >= 0; k--) free = free || !mdl[k].v;
`endif
        return free;
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] d, input logic [LANES-1:0] m,
                        input bit st, input bit fl, input bit rs);
        bit rdy, take, vac;
        int cnt;
        @(negedge clk);
        in_valid = v; in_data = d; in_mask = m; stall = st; flush = fl; reset = rs;
        #1;
        rdy = mdl_ready(st, fl);
        if (!rs) check("in_ready", DW'(in_ready), DW'(rdy));
        @(posedge clk);
        if (rs) begin
            for (int k = 0; k < DEPTH; k++) begin
                mdl[k].v = 1'b0; mdl[k].d = '0; mdl[k].m = '0;
            end
            mdrop = 0;
        end else begin
            if (v && !rdy && !fl && mdrop < DMAX) mdrop++;
            if (fl) begin
                for (int k = 0; k < DEPTH; k++) mdl[k].v = 1'b0;
            end else begin
                // Move items toward the output; a slot refills when it was vacated.
                vac = !st;
                for (int k = DEPTH-1; k >= 0; k--) begin
`ifdef PIPE_BUBBLE_COLLAPSE_EN
                    take = vac || !mdl[k].v;
`else
                    take = !st;
`endif
                    if (take) begin
                        if (k == 0) begin
                            mdl[0].v = v; mdl[0].d = masked(d, m); mdl[0].m = m;
                        end else begin
                            mdl[k] = mdl[k-1];
                        end
                    end
                    vac = take;
                end
            end
        end
        #1;
        cnt = 0;
        for (int k = 0; k < DEPTH; k++) cnt += int'(mdl[k].v);
        check("out_valid", DW'(out_valid), DW'(mdl[DEPTH-1].v));
        if (mdl[DEPTH-1].v || rs) begin
            check("out_data", out_data, mdl[DEPTH-1].d);
            check("out_mask", DW'(out_mask), DW'(mdl[DEPTH-1].m));
        end
        check("occupancy", DW'(occupancy), DW'(cnt));
        check("drop_count", DW'(drop_count), DW'(mdrop));
    endtask

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [DW-1:0] ramp;
    logic [DW-1:0] z;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; stall = 1'b0; flush = 1'b0;
        z = '0;
        for (int i = 0; i < LANES; i++) ramp[i*WIDTH +: WIDTH] = 64'((i+1)*10);

        step(0, z, 8'h00, 0, 0, 1);
        // basic flow, then lane mask
        step(1, ramp, 8'hFF, 0, 0, 0);
        repeat (5) step(0, z, 8'h00, 0, 0, 0);
        step(1, ramp, 8'h0F, 0, 0, 0);
        repeat (5) step(0, z, 8'h00, 0, 0, 0);
        // stall hold with input pending
        for (int i = 0; i < 4; i++) step(1, rnd_vec(), 8'(i + 8'hF0), 0, 0, 0);
        repeat (3) step(1, rnd_vec(), 8'hFF, 1, 0, 0);
        repeat (6) step(0, z, 8'h00, 0, 0, 0);
        // flush beats stall
        for (int i = 0; i < 4; i++) step(1, rnd_vec(), 8'hFF, 0, 0, 0);
        step(1, ramp, 8'hFF, 1, 1, 0);
        repeat (2) step(0, z, 8'h00, 0, 0, 0);
        // reset mid-stream
        for (int i = 0; i < 4; i++) step(1, rnd_vec(), 8'hFF, 0, 0, 0);
        step(1, rnd_vec(), 8'hFF, 0, 0, 1);
        step(1, ramp, 8'h3C, 0, 0, 0);
        repeat (5) step(0, z, 8'h00, 0, 0, 0);
        // bubbles followed by stall with continuous input
        for (int i = 0; i < 4; i++) step(i % 2 == 0, rnd_vec(), 8'hFF, 0, 0, 0);
        repeat (4) step(1, rnd_vec(), 8'hFF, 1, 0, 0);
        repeat (6) step(0, z, 8'h00, 0, 0, 0);
        // random traffic; long stalls drive the drop counter into saturation
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rnd_vec(), 8'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 22) == 0,
                 $urandom_range(0, 150) == 0);
        end
        repeat (20) step(1, rnd_vec(), 8'($urandom), 1, 0, 0);
        repeat (6) step(0, z, 8'h00, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
